reg_read_port: RTL and testbench
================================

REG_READ_PORT -- requirements
Module: reg_read_port

Interface
REQ-001 Parameter WIDTH, default 32, data width of each register and of the bus.
REQ-002 Parameter NREGS, default 16, number of registers in the bank; SHALL be a power of two.
REQ-003 clk  input  1  system clock; all state SHALL update on the rising edge only.
REQ-004 clr  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  read request present.
REQ-006 req_ready  output  1  block can accept a request.
REQ-007 req_addr  input  log2(NREGS)  first register index to read.
REQ-008 req_len  input  log2(NREGS)  number of registers to read minus one.
REQ-009 regs_q  input  NREGS*WIDTH  flattened register Q outputs; register i occupies bits [i*WIDTH +: WIDTH].
REQ-010 rout  output  NREGS  one-hot register output-enable strobe.
REQ-011 bus_data  output  WIDTH  registered read data.
REQ-012 bus_valid  output  1  bus_data holds a valid word.
REQ-013 bus_ready  input  1  downstream consumer accepts the word.
REQ-014 bus_last  output  1  the current word is the final word of the request.

Function
REQ-015 The block SHALL implement three states: IDLE, SELECT and HOLD.
REQ-016 req_ready SHALL be 1 only in IDLE.
REQ-017 A request is accepted on a rising edge where req_valid=1 and req_ready=1:
- cur_addr is loaded from req_addr.
- rem is loaded from req_len.
- The next state is SELECT.
REQ-018 In SELECT, rout SHALL equal the one-hot decode of cur_addr for exactly one cycle.
REQ-019 On the SELECT edge, bus_data SHALL load the regs_q slice at cur_addr, and the next state is HOLD.
REQ-020 rout SHALL be all-zero in every state other than SELECT.
REQ-021 In HOLD, bus_valid SHALL be 1 and bus_data SHALL remain stable until a rising edge where bus_ready=1.
REQ-022 bus_last SHALL be 1 in HOLD when rem=0, and 0 otherwise.
REQ-023 On a HOLD edge with bus_ready=1:
- If rem=0, the next state is IDLE.
- Otherwise, cur_addr becomes (cur_addr+1) mod NREGS, rem becomes rem-1, and the next state is SELECT.
REQ-024 Latency from request accept to the first bus_valid SHALL be 2 cycles; each subsequent word SHALL follow 2 cycles after the previous handshake.
REQ-025 The address SHALL wrap from NREGS-1 to 0 without error.
REQ-026 req_len=NREGS-1 SHALL read all NREGS registers exactly once.
REQ-027 bus_ready while not in HOLD SHALL be ignored.
REQ-028 req_valid while not in IDLE SHALL be ignored and SHALL NOT be queued.
REQ-029 bus_valid SHALL be 0 in IDLE and SELECT.

Reset
REQ-030 While clr=0, the block SHALL immediately force the following, independent of clk:
- State = IDLE.
- cur_addr = 0 and rem = 0.
- bus_data = 0.
- bus_valid = 0, bus_last = 0 and rout = 0.
- req_ready = 1.
REQ-031 Reset asserted mid-burst SHALL abandon the burst, and no further words SHALL be presented after release.
REQ-032 The first request SHALL be accepted on the first rising edge after clr returns to 1.

Structure
REQ-033 A shared package SHALL hold:
- The state encoding constants (IDLE, SELECT, HOLD).
- The default WIDTH and NREGS values.
REQ-034 The one-hot decode SHALL be a separate sub-module, rout_decoder: log2(NREGS)-bit index plus enable in, NREGS-bit one-hot out.

Verification
REQ-035 Single read: regs_q[i]=32'hA000_0000+i; request addr=5, len=0, bus_ready=1 -> rout=16'h0020 for one cycle, then bus_data=32'hA000_0005 with bus_valid=1 and bus_last=1, then IDLE.
REQ-036 Wrapping burst: request addr=14, len=2 -> words 32'hA000_000E, 32'hA000_000F, 32'hA000_0000 in order; bus_last=1 on the third word only.
REQ-037 Backpressure: bus_ready held 0 for 5 cycles in HOLD -> bus_valid and bus_data stable for all 5 cycles, then advance on the first cycle with bus_ready=1.
REQ-038 Busy request: req_valid=1 with addr=3 during a burst -> req_ready=0, the request is ignored, and no word from register 3 appears.
REQ-039 Async reset: clr=0 between clock edges during the second word of a len=3 burst -> all outputs at reset values before the next edge, req_ready=1 after release.
REQ-040 Full sweep: addr=0, len=15 -> 16 words, registers 0..15 in order, rout strobing each bit once.

Source files
------------

// File: rtl/reg_read_port_pkg.sv
// -----------------------------------------------------------------------------
// reg_read_port_pkg
// Shared definitions for the register read port:
//   - DEF_WIDTH / DEF_NREGS : default data width and register count
//   - state_t               : FSM state encoding (IDLE, SELECT, HOLD)
//   - is_pow2()             : elaboration-time helper for parameter checks
// -----------------------------------------------------------------------------
package reg_read_port_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_NREGS = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    function automatic bit is_pow2(input int n);
        return (n > 1) && ((n & (n - 1)) == 0);
    endfunction

endpackage : reg_read_port_pkg

// File: rtl/reg_read_port_if.sv
// -----------------------------------------------------------------------------
// reg_read_port_if
// Request and read-data bus of the register read port.
//
// Handshake rules (both channels):
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   The side driving valid keeps its payload stable while valid=1 and ready=0.
//   - Request channel : req_valid/req_addr/req_len from master, req_ready from
//                       slave. req_ready is 1 only while the slave is idle; a
//                       request offered while it is busy is dropped, not queued.
//   - Read channel    : bus_valid/bus_data/bus_last from slave, bus_ready from
//                       master. bus_ready is only looked at while a word is held.
//
// Modports:
//   slave  : the read port itself (accepts requests, produces words)
//   master : the requester / word consumer
// -----------------------------------------------------------------------------
interface reg_read_port_if
    import reg_read_port_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREGS = DEF_NREGS
) ();

    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic             req_valid;
    logic             req_ready;
    logic [AW-1:0]    req_addr;
    logic [AW-1:0]    req_len;

    logic [WIDTH-1:0] bus_data;
    logic             bus_valid;
    logic             bus_ready;
    logic             bus_last;

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_len,
        input  bus_ready,
        output req_ready,
        output bus_data,
        output bus_valid,
        output bus_last
    );

    modport master (
        output req_valid,
        output req_addr,
        output req_len,
        output bus_ready,
        input  req_ready,
        input  bus_data,
        input  bus_valid,
        input  bus_last
    );

endinterface : reg_read_port_if

// File: rtl/reg_read_port_rout_decoder.sv
// -----------------------------------------------------------------------------
// rout_decoder
// One-hot decoder for the register output-enable strobes.
// Ports:
//   idx_i    : register index (log2(NREGS) bits)
//   en_i     : decode enable; output is all-zero when 0
//   onehot_o : NREGS-bit one-hot strobe, bit idx_i set when enabled
// -----------------------------------------------------------------------------
module rout_decoder #(
    parameter int NREGS = 16,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic [AW-1:0]    idx_i,
    input  logic             en_i,
    output logic [NREGS-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[idx_i] = 1'b1;
        end
    end

endmodule : rout_decoder

// File: rtl/reg_read_port.sv
// -----------------------------------------------------------------------------
// reg_read_port
// Burst read port over a flat register bank. A request names a first register
// and a length; the block walks the registers one at a time, strobing the
// register's output enable for one cycle (SELECT), then presenting the captured
// word on the read bus until the consumer takes it (HOLD). Addresses wrap
// modulo NREGS.
//
// Ports:
//   clk     : system clock, rising edge
//   clr     : asynchronous active-low reset
//   rp      : request + read bus (slave modport of reg_read_port_if)
//   regs_q  : flattened register outputs, register i at [i*WIDTH +: WIDTH]
//   rout    : one-hot register output-enable strobe (SELECT only)
//   state_o : current FSM state, for observation
// -----------------------------------------------------------------------------
module reg_read_port
    import reg_read_port_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREGS = DEF_NREGS
) (
    input  logic                   clk,
    input  logic                   clr,
    reg_read_port_if.slave         rp,
    input  logic [NREGS*WIDTH-1:0] regs_q,
    output logic [NREGS-1:0]       rout,
    output state_t                 state_o
);

    localparam int AW = $clog2(NREGS);

    // The address counter relies on natural AW-bit wraparound.
    if (!is_pow2(NREGS)) begin : g_bad_nregs
        $error("reg_read_port: NREGS must be a power of two greater than 1");
    end

    // ---------------------------------------------------------------------
    // Register bank as an array so the read mux indexes by cur_addr directly
    // ---------------------------------------------------------------------
    logic [WIDTH-1:0] regs_arr [NREGS];

    for (genvar g = 0; g < NREGS; g++) begin : g_unpack
        assign regs_arr[g] = regs_q[g*WIDTH +: WIDTH];
    end

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    state_t           state_q;
    logic [AW-1:0]    cur_addr_q;
    logic [AW-1:0]    rem_q;
    logic [WIDTH-1:0] bus_data_q;
    logic             bus_valid_q;
    logic             bus_last_q;

    logic [WIDTH-1:0] sel_word;

    assign sel_word = regs_arr[cur_addr_q];

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q     <= ST_IDLE;
            cur_addr_q  <= '0;
            rem_q       <= '0;
            bus_data_q  <= '0;
            bus_valid_q <= 1'b0;
            bus_last_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // req_ready is 1 here by construction
                    if (rp.req_valid) begin
                        cur_addr_q <= rp.req_addr;
                        rem_q      <= rp.req_len;
                        state_q    <= ST_SELECT;
                    end
                end

                ST_SELECT: begin
                    // Capture happens while the strobe for cur_addr is active.
                    bus_data_q  <= sel_word;
                    bus_valid_q <= 1'b1;
                    bus_last_q  <= (rem_q == '0);
                    state_q     <= ST_HOLD;
                end

                ST_HOLD: begin
                    if (rp.bus_ready) begin
                        bus_valid_q <= 1'b0;
                        bus_last_q  <= 1'b0;
                        if (rem_q == '0) begin
                            state_q <= ST_IDLE;
                        end else begin
                            cur_addr_q <= cur_addr_q + 1'b1;
                            rem_q      <= rem_q - 1'b1;
                            state_q    <= ST_SELECT;
                        end
                    end
                end

                default: begin
                    state_q     <= ST_IDLE;
                    bus_valid_q <= 1'b0;
                    bus_last_q  <= 1'b0;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Output-enable strobe, only while selecting
    // ---------------------------------------------------------------------
    rout_decoder #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_rout_decoder (
        .idx_i    (cur_addr_q),
        .en_i     (state_q == ST_SELECT),
        .onehot_o (rout)
    );

    // ---------------------------------------------------------------------
    // Bus outputs
    // ---------------------------------------------------------------------
    assign rp.req_ready = (state_q == ST_IDLE);
    assign rp.bus_data  = bus_data_q;
    assign rp.bus_valid = bus_valid_q;
    assign rp.bus_last  = bus_last_q;
    assign state_o      = state_q;

endmodule : reg_read_port

// File: tb/tb_reg_read_port.sv
// -----------------------------------------------------------------------------
// tb_reg_read_port
// Self-checking bench for reg_read_port. Expected words come from an array
// model of the register bank: a burst (addr, len) yields regs[(addr+k) % N]
// for k = 0..len, the last one flagged, each preceded by a one-cycle strobe.
// -----------------------------------------------------------------------------
module tb_reg_read_port;
    import reg_read_port_pkg::*;

    localparam int W  = 32;
    localparam int N  = 16;
    localparam int AW = 4;

    // ---------------------------------------------------------------------
    // Clock / reset
    // ---------------------------------------------------------------------
    logic clk = 1'b0;
    logic clr;

    always #5 clk = ~clk;

    // ---------------------------------------------------------------------
    // DUT
    // ---------------------------------------------------------------------
    reg_read_port_if #(.WIDTH(W), .NREGS(N)) bif ();

    logic [N*W-1:0] regs_flat;
    logic [N-1:0]   rout;
    state_t         state_dbg;

    reg_read_port #(
        .WIDTH (W),
        .NREGS (N)
    ) dut (
        .clk     (clk),
        .clr     (clr),
        .rp      (bif),
        .regs_q  (regs_flat),
        .rout    (rout),
        .state_o (state_dbg)
    );

    // ---------------------------------------------------------------------
    // Model + scoreboard
    // ---------------------------------------------------------------------
    int           checks   = 0;
    int           failures = 0;
    logic [W-1:0] regs_m [N];
    logic [W-1:0] exp_q [$];
    logic         exp_last_q [$];
    logic [N-1:0] exp_rout_q [$];
    logic [N-1:0] rout_seen;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_regs(input bit directed);
        for (int i = 0; i < N; i++) begin
            regs_m[i] = directed ? (32'hA000_0000 + i) : $urandom;
            regs_flat[i*W +: W] = regs_m[i];
        end
    endtask

    task automatic build_expect(input int addr, input int len);
        logic [N-1:0] one;
        int           idx;
        one = 1;
        exp_q.delete();
        exp_last_q.delete();
        exp_rout_q.delete();
        for (int k = 0; k <= len; k++) begin
            idx = (addr + k) % N;
            exp_q.push_back(regs_m[idx]);
            exp_last_q.push_back(k == len);
            exp_rout_q.push_back(one << idx);
        end
    endtask

    // Runs one burst from IDLE (entered at posedge+1) and checks every cycle.
    task automatic run_burst(input int addr, input int len, input int stall_max,
                             input int stall_fixed, input bit busy_req,
                             input int busy_addr, input string name);
        logic [W-1:0] ew;
        logic         el;
        logic [N-1:0] er;
        int           n;

        build_expect(addr, len);

        checks++;
        if (bif.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s idle_ready: req_ready=%b expected 1", name, bif.req_ready);
        end

        bif.req_valid = 1'b1;
        bif.req_addr  = addr[AW-1:0];
        bif.req_len   = len[AW-1:0];
        bif.bus_ready = 1'($urandom_range(0, 1));
        tick();

        if (busy_req) begin
            bif.req_valid = 1'b1;
            bif.req_addr  = busy_addr[AW-1:0];
            bif.req_len   = 4'($urandom_range(0, N - 1));
        end else begin
            bif.req_valid = 1'b0;
        end

        rout_seen = '0;
        while (exp_q.size() > 0) begin
            ew = exp_q.pop_front();
            el = exp_last_q.pop_front();
            er = exp_rout_q.pop_front();

            // SELECT cycle
            checks++;
            if (rout !== er || bif.bus_valid !== 1'b0 || bif.req_ready !== 1'b0) begin
                failures++;
                $display("FAIL %s select: rout=%h bus_valid=%b req_ready=%b expected rout=%h bus_valid=0 req_ready=0",
                         name, rout, bif.bus_valid, bif.req_ready, er);
            end
            rout_seen = rout_seen | rout;
            bif.bus_ready = 1'($urandom_range(0, 1));   // ignored while selecting
            tick();

            // HOLD cycle
            checks++;
            if (bif.bus_valid !== 1'b1 || bif.bus_data !== ew || bif.bus_last !== el ||
                rout !== '0 || bif.req_ready !== 1'b0) begin
                failures++;
                $display("FAIL %s hold: valid=%b data=%h last=%b rout=%h ready=%b expected valid=1 data=%h last=%b rout=0 ready=0",
                         name, bif.bus_valid, bif.bus_data, bif.bus_last, rout, bif.req_ready, ew, el);
            end

            n = (stall_fixed >= 0) ? stall_fixed : $urandom_range(0, stall_max);
            bif.bus_ready = 1'b0;
            repeat (n) begin
                tick();
                checks++;
                if (bif.bus_valid !== 1'b1 || bif.bus_data !== ew || bif.bus_last !== el) begin
                    failures++;
                    $display("FAIL %s stall: valid=%b data=%h last=%b expected valid=1 data=%h last=%b",
                             name, bif.bus_valid, bif.bus_data, bif.bus_last, ew, el);
                end
            end

            bif.bus_ready = 1'b1;
            tick();
            if (exp_q.size() == 0) begin
                bif.req_valid = 1'b0;
            end
            bif.bus_ready = 1'($urandom_range(0, 1));
        end

        checks++;
        if (bif.req_ready !== 1'b1 || bif.bus_valid !== 1'b0 || rout !== '0) begin
            failures++;
            $display("FAIL %s end_idle: req_ready=%b bus_valid=%b rout=%h expected 1 0 0",
                     name, bif.req_ready, bif.bus_valid, rout);
        end

        // No queued or stray request may start another burst.
        tick();
        checks++;
        if (bif.bus_valid !== 1'b0 || rout !== '0 || bif.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s stay_idle: bus_valid=%b rout=%h req_ready=%b expected 0 0 1",
                     name, bif.bus_valid, rout, bif.req_ready);
        end
    endtask

    // ---------------------------------------------------------------------
    // Scenarios
    // ---------------------------------------------------------------------
    task automatic test_reset();
        clr = 1'b0;
        #3;
        checks++;
        if (bif.req_ready !== 1'b1 || bif.bus_valid !== 1'b0 || bif.bus_last !== 1'b0 ||
            bif.bus_data !== '0 || rout !== '0 || state_dbg !== ST_IDLE) begin
            failures++;
            $display("FAIL reset: ready=%b valid=%b last=%b data=%h rout=%h state=%0d expected 1 0 0 0 0 IDLE",
                     bif.req_ready, bif.bus_valid, bif.bus_last, bif.bus_data, rout, state_dbg);
        end
        @(negedge clk);
        clr = 1'b1;
        tick();
    endtask

    task automatic test_single();
        load_regs(1'b1);
        run_burst(5, 0, 0, 0, 1'b0, 0, "single");
    endtask

    task automatic test_wrap();
        load_regs(1'b1);
        run_burst(14, 2, 2, -1, 1'b0, 0, "wrap");
    endtask

    task automatic test_backpressure();
        load_regs(1'b1);
        run_burst(7, 1, 0, 5, 1'b0, 0, "backpressure");
    endtask

    task automatic test_busy();
        load_regs(1'b1);
        run_burst(8, 4, 2, -1, 1'b1, 3, "busy");
    endtask

    task automatic test_sweep();
        load_regs(1'b1);
        run_burst(0, 15, 1, -1, 1'b0, 0, "sweep");
        checks++;
        if (rout_seen !== {N{1'b1}}) begin
            failures++;
            $display("FAIL sweep_rout_cover: seen=%h expected %h", rout_seen, {N{1'b1}});
        end
    endtask

    task automatic test_async_reset();
        load_regs(1'b1);
        bif.req_valid = 1'b1;
        bif.req_addr  = 4'd2;
        bif.req_len   = 4'd3;
        bif.bus_ready = 1'b0;
        tick();                     // SELECT word 0
        bif.req_valid = 1'b0;
        tick();                     // HOLD word 0
        bif.bus_ready = 1'b1;
        tick();                     // SELECT word 1
        bif.bus_ready = 1'b0;
        tick();                     // HOLD word 1
        checks++;
        if (bif.bus_valid !== 1'b1 || bif.bus_data !== regs_m[3]) begin
            failures++;
            $display("FAIL areset_pre: valid=%b data=%h expected 1 %h",
                     bif.bus_valid, bif.bus_data, regs_m[3]);
        end
        #2;
        clr = 1'b0;
        #1;
        checks++;
        if (bif.req_ready !== 1'b1 || bif.bus_valid !== 1'b0 || bif.bus_last !== 1'b0 ||
            bif.bus_data !== '0 || rout !== '0 || state_dbg !== ST_IDLE) begin
            failures++;
            $display("FAIL areset_async: ready=%b valid=%b last=%b data=%h rout=%h state=%0d expected 1 0 0 0 0 IDLE",
                     bif.req_ready, bif.bus_valid, bif.bus_last, bif.bus_data, rout, state_dbg);
        end
        bif.bus_ready = 1'b1;
        repeat (2) tick();
        // A request waiting at release is taken on the first edge.
        bif.req_valid = 1'b1;
        bif.req_addr  = 4'd9;
        bif.req_len   = 4'd0;
        @(negedge clk);
        clr = 1'b1;
        tick();
        bif.req_valid = 1'b0;
        checks++;
        if (rout !== 16'h0200 || bif.req_ready !== 1'b0 || bif.bus_valid !== 1'b0) begin
            failures++;
            $display("FAIL areset_first_accept: rout=%h ready=%b valid=%b expected 0200 0 0",
                     rout, bif.req_ready, bif.bus_valid);
        end
        tick();
        checks++;
        if (bif.bus_valid !== 1'b1 || bif.bus_data !== regs_m[9] || bif.bus_last !== 1'b1) begin
            failures++;
            $display("FAIL areset_word: valid=%b data=%h last=%b expected 1 %h 1",
                     bif.bus_valid, bif.bus_data, bif.bus_last, regs_m[9]);
        end
        tick();
        bif.bus_ready = 1'b1;
        repeat (4) begin
            checks++;
            if (bif.bus_valid !== 1'b0 || rout !== '0 || bif.req_ready !== 1'b1) begin
                failures++;
                $display("FAIL areset_abandon: valid=%b rout=%h ready=%b expected 0 0 1",
                         bif.bus_valid, rout, bif.req_ready);
            end
            tick();
        end
        bif.bus_ready = 1'b0;
    endtask

    task automatic test_random();
        int a;
        int l;
        for (int t = 0; t < 20; t++) begin
            load_regs(1'b0);
            a = $urandom_range(0, N - 1);
            l = $urandom_range(0, N - 1);
            run_burst(a, l, 3, -1, 1'($urandom_range(0, 1)), $urandom_range(0, N - 1), "random");
        end
    endtask

    initial begin
        bif.req_valid = 1'b0;
        bif.req_addr  = '0;
        bif.req_len   = '0;
        bif.bus_ready = 1'b0;
        regs_flat     = '0;
        rout_seen     = '0;

        test_reset();
        test_single();
        test_wrap();
        test_backpressure();
        test_busy();
        test_sweep();
        test_async_reset();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_reg_read_port
